// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operand/result stream bundle for the pipelined CLA adder-subtractor
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             op_sub;
    logic             c_in;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, data_a, data_b, op_sub, c_in, in_tag, out_ready,
        input  in_ready, out_valid, data_out, c_out, ovf, zero, out_tag
    );

    modport slave (
        input  in_valid, data_a, data_b, op_sub, c_in, in_tag, out_ready,
        output in_ready, out_valid, data_out, c_out, ovf, zero, out_tag
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - STAGES-deep carry-lookahead add/sub; CLA_ADDSUB_SAT_EN enables saturation
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int BPS  = NBLK / STAGES;

    // Index s holds the result of stage s; the last index doubles as the output register.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic [TAG_W-1:0] t_q [STAGES];
    logic             ovf_q, zero_q;

    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic [TAG_W-1:0] t_d [STAGES];
    logic             ovf_d, zero_d;

    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [TAG_W-1:0] src_t [STAGES];

    logic             adv;
    logic             cmsb;
    logic [WIDTH-1:0] dout;

    assign adv          = !v_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        logic gacc, pall, cblk, cb;
        int   lo;
        gacc = 1'b0;
        pall = 1'b1;
        cblk = 1'b0;
        cb   = 1'b0;
        lo   = 0;
        cmsb = 1'b0;
        src_v[0] = bus.in_valid;
        src_a[0] = bus.data_a;
        src_b[0] = bus.data_b ^ {WIDTH{bus.op_sub}};
        src_s[0] = '0;
        src_c[0] = bus.op_sub | bus.c_in;
        src_t[0] = bus.in_tag;
        for (int s = 1; s < STAGES; s++) begin
            src_v[s] = v_q[s-1];
            src_a[s] = a_q[s-1];
            src_b[s] = b_q[s-1];
            src_s[s] = s_q[s-1];
            src_c[s] = c_q[s-1];
            src_t[s] = t_q[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            v_d[s] = src_v[s];
            a_d[s] = src_a[s];
            b_d[s] = src_b[s];
            s_d[s] = src_s[s];
            t_d[s] = src_t[s];
            cb     = src_c[s];
            for (int k = 0; k < BPS; k++) begin
                lo = (s * BPS + k) * BLOCK;
                // Each bit carry is a flat sum of products from the block carry-in; i == BLOCK yields group G/P.
                for (int i = 0; i <= BLOCK; i++) begin
                    gacc = 1'b0;
                    pall = 1'b1;
                    for (int j = i - 1; j >= 0; j--) begin
                        gacc = gacc | (src_a[s][lo+j] & src_b[s][lo+j] & pall);
                        pall = pall & (src_a[s][lo+j] | src_b[s][lo+j]);
                    end
                    if (i < BLOCK) begin
                        s_d[s][lo+i] = src_a[s][lo+i] ^ src_b[s][lo+i] ^ (gacc | (pall & cb));
                        if (lo + i == WIDTH - 1)
                            cmsb = gacc | (pall & cb);
                    end else begin
                        cblk = gacc | (pall & cb);
                    end
                end
                cb = cblk;
            end
            c_d[s] = cb;
        end
        ovf_d = cmsb ^ c_d[STAGES-1];
        dout  = s_d[STAGES-1];
`ifdef CLA_ADDSUB_SAT_EN
        // A carry into the MSB on overflow means two positives wrapped negative.
        if (ovf_d)
            dout = {~cmsb, {(WIDTH-1){cmsb}}};
`endif
        s_d[STAGES-1] = dout;
        zero_d        = (dout == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
                c_q[s] <= 1'b0;
                t_q[s] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= v_d[s];
                a_q[s] <= a_d[s];
                b_q[s] <= b_d[s];
                s_q[s] <= s_d[s];
                c_q[s] <= c_d[s];
                t_q[s] <= t_d[s];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.data_out  = s_q[STAGES-1];
    assign bus.c_out     = c_q[STAGES-1];
    assign bus.out_tag   = t_q[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
    localparam int W  = 32;
    localparam int TW = 5;
    localparam int ST = 2;
`ifdef CLA_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        o;
        logic        z;
        logic [4:0]  t;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic        cin;
        logic [4:0]  tag;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   npop = 0;
    res_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(W), .TAG_W(TW)) ifc ();

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(8), .STAGES(ST), .TAG_W(TW)) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (ifc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                   input logic cin, input logic [4:0] tag);
        res_t        r;
        logic [32:0] w;
        if (!op) w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        else     w = {1'b0, a} - {1'b0, b};
        r.d = w[31:0];
        r.c = op ? (a >= b) : w[32];
        r.o = op ? (a[31] != b[31] && r.d[31] != a[31]) : (a[31] == b[31] && r.d[31] != a[31]);
        if (SAT && r.o) r.d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.z = (r.d == 32'd0);
        r.t = tag;
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                                input logic cin, input logic [4:0] tag, input logic [31:0] d,
                                input logic c, input logic o, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.cin = cin; v.tag = tag;
        v.exp.d = d; v.exp.c = c; v.exp.o = o; v.exp.z = z; v.exp.t = tag;
        return v;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_out(input string n, input res_t e);
        chk({n, "_data"}, 64'(ifc.data_out), 64'(e.d));
        chk({n, "_cout"}, 64'(ifc.c_out), 64'(e.c));
        chk({n, "_ovf"},  64'(ifc.ovf), 64'(e.o));
        chk({n, "_zero"}, 64'(ifc.zero), 64'(e.z));
        chk({n, "_tag"},  64'(ifc.out_tag), 64'(e.t));
    endtask

    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic cin, input logic [4:0] tag, input logic ordy, output logic acc);
        ifc.in_valid  = iv;
        ifc.data_a    = a;
        ifc.data_b    = b;
        ifc.op_sub    = op;
        ifc.c_in      = cin;
        ifc.in_tag    = tag;
        ifc.out_ready = ordy;
        #1;
        acc = iv && ifc.in_ready;
        if (acc) q.push_back(model(a, b, op, cin, tag));
        if (ifc.out_valid && ifc.out_ready) begin
            npop++;
            if (q.size() == 0) chk("spurious_out", 64'(ifc.out_tag), 64'hFFFF);
            else               check_out("stream", q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tv[9];
        logic acc;
        int   next_tag;
        int   nacc;
        int   pop_before;

        ifc.in_valid = 1'b0; ifc.data_a = '0; ifc.data_b = '0; ifc.op_sub = 1'b0;
        ifc.c_in = 1'b0; ifc.in_tag = '0; ifc.out_ready = 1'b1;

        @(negedge clk); @(negedge clk);
        chk("rst_valid", 64'(ifc.out_valid), 64'(0));
        chk("rst_data",  64'(ifc.data_out), 64'(0));
        chk("rst_flags", 64'({ifc.c_out, ifc.ovf, ifc.zero}), 64'(0));
        chk("rst_tag",   64'(ifc.out_tag), 64'(0));
        chk("rst_ready", 64'(ifc.in_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        tv[0] = mk(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 1'b1);
        tv[1] = mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 5'd5,
                   SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tv[2] = mk(32'd5, 32'd7, 1'b1, 1'b0, 5'd6, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tv[3] = mk(32'd7, 32'd5, 1'b1, 1'b0, 5'd7, 32'd2, 1'b1, 1'b0, 1'b0);
        tv[4] = mk(32'd1, 32'd2, 1'b0, 1'b1, 5'd8, 32'd4, 1'b0, 1'b0, 1'b0);
        tv[5] = mk(32'h8000_0000, 32'd1, 1'b1, 1'b0, 5'd10,
                   SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tv[6] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 5'd11,
                   SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1);
        tv[7] = mk(32'd0, 32'd0, 1'b1, 1'b1, 5'd12, 32'd0, 1'b1, 1'b0, 1'b1);
        tv[8] = mk(32'h1234_5678, 32'd0, 1'b0, 1'b1, 5'd31, 32'h1234_5679, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            ifc.in_valid = 1'b1; ifc.data_a = tv[i].a; ifc.data_b = tv[i].b;
            ifc.op_sub = tv[i].op; ifc.c_in = tv[i].cin; ifc.in_tag = tv[i].tag; ifc.out_ready = 1'b1;
            @(negedge clk);
            ifc.in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), 64'(ifc.out_valid), 64'(0));
            repeat (ST - 1) @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(ifc.out_valid), 64'(1));
            check_out($sformatf("vec%0d", i), tv[i].exp);
            @(negedge clk);
        end

        // Backpressure: two accepted, three stalled cycles, then drain.
        npop = 0;
        next_tag = 1;
        for (int c = 0; c < 30 && npop < 4; c++) begin
            if (c == 3) begin
                chk("bp_ready_low", 64'(ifc.in_ready), 64'(0));
                chk("bp_valid_held", 64'(ifc.out_valid), 64'(1));
                chk("bp_tag_held", 64'(ifc.out_tag), 64'(1));
            end
            if (c == 5) chk("bp_tag_still_held", 64'(ifc.out_tag), 64'(1));
            cycle(next_tag <= 4, $urandom, $urandom, 1'($urandom), 1'($urandom),
                  5'(next_tag), c >= 5, acc);
            if (acc) next_tag++;
        end
        chk("bp_pop_count", 64'(npop), 64'(4));
        chk("bp_queue_empty", 64'(q.size()), 64'(0));

        // Reset with tag 9 in flight.
        cycle(1'b1, 32'd100, 32'd23, 1'b0, 1'b0, 5'd9, 1'b1, acc);
        chk("rst9_accept", 64'(acc), 64'(1));
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
            q.delete();
            chk("rst9_valid", 64'(ifc.out_valid), 64'(0));
            chk("rst9_outs", 64'({ifc.data_out, ifc.c_out, ifc.ovf, ifc.zero, ifc.out_tag}), 64'(0));
            chk("rst9_ready", 64'(ifc.in_ready), 64'(1));
        end
        rst_n = 1'b1;
        pop_before = npop;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
            chk("rst9_no_result", 64'(ifc.out_valid), 64'(0));
        end
        chk("rst9_no_pop", 64'(npop), 64'(pop_before));

        // Random traffic with random stalls against the arithmetic model.
        nacc = 0;
        for (int c = 0; c < 60000 && nacc < 10000; c++) begin
            cycle($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
                  5'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) nacc++;
        end
        chk("rand_accepted", 64'(nacc), 64'(10000));
        for (int c = 0; c < 50 && q.size() > 0; c++)
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, acc);
        chk("rand_drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL expose parameter WIDTH, default 32: operand and result width; must be a multiple of BLOCK.
REQ-002 SHALL expose parameter BLOCK, default 8: bits per lookahead block; each block produces group P/G.
REQ-003 SHALL expose parameter STAGES, default 2: pipeline register stages; WIDTH/BLOCK must be divisible by STAGES, and STAGES must be at least 1.
REQ-004 SHALL expose parameter TAG_W, default 5: width of the sideband tag carried alongside each operation.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-007 in_valid  in  1  operands, op and tag are presented this cycle.
REQ-008 in_ready  out  1  block accepts an operation this cycle.
REQ-009 data_a, data_b  in  WIDTH  operands, two's complement.
REQ-010 op_sub  in  1  0 = a+b+c_in; 1 = a-b (b inverted, carry-in forced 1, c_in ignored).
REQ-011 c_in  in  1  carry-in for add.
REQ-012 in_tag  in  TAG_W  opaque tag returned with the result.
REQ-013 out_valid  out  1  result fields are valid.
REQ-014 out_ready  in  1  consumer takes the result this cycle.
REQ-015 data_out  out  WIDTH  sum/difference; c_out  out  1  carry-out of MSB; ovf  out  1  signed overflow; zero  out  1  data_out == 0; out_tag  out  TAG_W.

Function
REQ-016 SHALL compute per-bit g = a&b', p = a|b', where b' = b XOR {WIDTH{op_sub}}, and SHALL combine them per BLOCK into group P/G with lookahead carries across blocks.
REQ-017 SHALL assign blocks to stages in order, WIDTH/(BLOCK*STAGES) blocks per stage, LSB blocks first; inter-stage carry and not-yet-consumed operand bits SHALL be registered at each stage boundary.
REQ-018 SHALL fold ripple between blocks inside a stage as lookahead (c_next = G | P&c), with no ripple through a block's bits.
REQ-019 Global advance: adv = !out_valid | out_ready; in_ready = adv; every pipeline register SHALL load only when adv is 1.
REQ-020 An operation is accepted when in_valid & in_ready; its result SHALL appear on out_valid exactly STAGES cycles later if adv stays 1 throughout.
REQ-021 When adv is 0, all stage contents and outputs SHALL hold unchanged (no loss, no duplication).
REQ-022 Per-stage valid bits SHALL propagate with the data; bubbles SHALL be allowed and SHALL NOT produce out_valid.
REQ-023 ovf = carry into MSB XOR carry out of MSB; c_out for subtract = NOT borrow (1 when a >= b unsigned).
REQ-024 zero SHALL be computed from the final data_out value, including any saturation.
REQ-025 Accept while out_valid & out_ready in the same cycle SHALL be supported at full throughput, one operation per cycle.
REQ-026 out_tag SHALL equal the in_tag of the same operation; ordering SHALL be strictly FIFO.

Reset
REQ-027 While reset_n = 0 at a clock edge: all stage valid bits, out_valid, data_out, c_out, ovf, zero and out_tag SHALL become 0.
REQ-028 In-flight operations SHALL be discarded on reset; in_ready SHALL read 1 during and after reset.

Configuration
REQ-029 Macro CLA_ADDSUB_SAT_EN defined: when ovf = 1, data_out SHALL saturate to 0x7F..F (positive overflow) or 0x80..0 (negative overflow); ovf and c_out still report the raw condition.
REQ-030 Macro CLA_ADDSUB_SAT_EN undefined: data_out SHALL be the wrapped modulo-2^WIDTH result; no saturation logic is present.

Verification (WIDTH=32, BLOCK=8, STAGES=2, TAG_W=5)
REQ-031 Add 0xFFFFFFFF + 0x00000001, c_in=0, tag 3, out_ready=1 -> 2 cycles later: data_out=0, c_out=1, ovf=0, zero=1, out_tag=3.
REQ-032 Add 0x7FFFFFFF + 0x00000001 -> data_out=0x80000000, ovf=1 without the macro; data_out=0x7FFFFFFF, ovf=1 with CLA_ADDSUB_SAT_EN.
REQ-033 Sub 5 - 7 -> data_out=0xFFFFFFFE, c_out=0, ovf=0; sub 7 - 5 -> data_out=2, c_out=1.
REQ-034 Issue tags 1..4 back-to-back, out_ready=0 for 3 cycles -> in_ready drops once out_valid is set; after release, tags 1,2,3,4 emerge in order, none lost or repeated.
REQ-035 Issue tag 9, assert reset_n=0 one cycle later -> out_valid=0 and all outputs 0 for 2+ cycles; no tag-9 result appears.
REQ-036 Random 10k operations with random in_valid/out_ready -> each result matches a+b+c_in or a-b reference model with correct c_out, ovf and zero.
